// File: rtl/aes128_decrypt_iter_if.sv
// Handshake bundle for the iterative AES-128 decryptor: ciphertext/key in, plaintext out.
interface aes128_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] IN_DATA;
    logic [127:0] IN_KEY;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] OUT_DATA;

    modport master (
        output in_valid, IN_DATA, IN_KEY, out_ready,
        input  in_ready, out_valid, OUT_DATA
    );
    modport slave (
        input  in_valid, IN_DATA, IN_KEY, out_ready,
        output in_ready, out_valid, OUT_DATA
    );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: ten forward key-expansion cycles, then ten inverse
// rounds that walk the key schedule backwards one round key per cycle.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = TABLE[a];
endmodule

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = TABLE[a];
endmodule

module aes128_decrypt_iter (
    input  logic                  clk,
    input  logic                  resetn,
    aes128_decrypt_iter_if.slave  bus
);
    localparam int NUM_COLS  = 4;
    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [127:0] ct_reg, ct_nxt;
    logic [127:0] key_reg, key_nxt;
    logic [127:0] data_reg, data_nxt;
    logic [127:0] out_data_q, out_data_nxt;
    logic         out_valid_q, out_valid_nxt;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [0:3][7:0] s, x2, x4, x8, m9, mb, md, me;
        s = col;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xt(s[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [127:0] o;
        for (int c = 0; c < NUM_COLS; c++)
            o[127-32*c -: 32] = inv_mix_col(v[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Key schedule: the same SubWord(RotWord()) serves forward expansion (on w3)
    // and backward derivation (on the recovered p3 = w3^w2).
    logic [31:0]     w0, w1, w2, w3, p0, p1, p2, p3, ks_word, ks_tmp;
    logic [0:3][7:0] ks_rot, ks_sub;
    logic [127:0]    key_fwd, prev_key;

    assign {w0, w1, w2, w3} = key_reg;
    assign p3      = w3 ^ w2;
    assign p2      = w2 ^ w1;
    assign p1      = w1 ^ w0;
    assign ks_word = (state == ROUND) ? p3 : w3;
    assign ks_rot  = {ks_word[23:0], ks_word[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
            sbox u_sbox (.a(ks_rot[i]), .y(ks_sub[i]));
        end
    endgenerate

    assign ks_tmp = ks_sub ^ {rcon(cnt), 24'h0};
    assign p0     = w0 ^ ks_tmp;

    logic [31:0] f0, f1, f2, f3;
    assign f0       = w0 ^ ks_tmp;
    assign f1       = w1 ^ f0;
    assign f2       = w2 ^ f1;
    assign f3       = w3 ^ f2;
    assign key_fwd  = {f0, f1, f2, f3};
    assign prev_key = {p0, p1, p2, p3};

    // Data path: InvShiftRows is pure wiring into the inverse S-boxes.
    logic [0:15][7:0] d_b, isb_b;
    logic [127:0]     rnd_t;

    assign d_b = data_reg;

    generate
        for (genvar i = 0; i < NUM_BYTES; i++) begin : g_inv_sbox
            localparam int SRC = (((i / 4) - (i % 4) + 4) % 4) * 4 + (i % 4);
            inv_sbox u_inv_sbox (.a(d_b[SRC]), .y(isb_b[i]));
        end
    endgenerate

    assign rnd_t = isb_b ^ prev_key;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ct_nxt        = ct_reg;
        key_nxt       = key_reg;
        data_nxt      = data_reg;
        out_data_nxt  = out_data_q;
        out_valid_nxt = out_valid_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    ct_nxt    = bus.IN_DATA;
                    key_nxt   = bus.IN_KEY;
                    cnt_nxt   = 4'd1;
                    state_nxt = KEYEXP;
                end
            end
            KEYEXP: begin
                key_nxt = key_fwd;
                if (cnt == 4'd10) begin
                    data_nxt  = ct_reg ^ key_fwd;
                    state_nxt = ROUND;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ROUND: begin
                key_nxt  = prev_key;
                cnt_nxt  = cnt - 4'd1;
                data_nxt = (cnt > 4'd1) ? inv_mix(rnd_t) : rnd_t;
                if (cnt == 4'd1) begin
                    out_data_nxt  = rnd_t;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ct_reg      <= '0;
            key_reg     <= '0;
            data_reg    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ct_reg      <= ct_nxt;
            key_reg     <= key_nxt;
            data_reg    <= data_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter against a table-free behavioural AES model.
module tb_aes128_decrypt_iter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aes128_decrypt_iter_if bus();
    aes128_decrypt_iter dut (.clk(clk), .resetn(resetn), .bus(bus));

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] LB_KEY  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] LB_PT   = 128'hd7e5dbd3324595f8fdc7d7c571da6c2a;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] exp_q[$];
    string        name_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [127:0] e, input string name);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // ---------------- reference model: GF(2^8) arithmetic from first principles
    logic [7:0] sbt[256];
    logic [7:0] isbt[256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v, inv, b;
            v   = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(v, y[7:0]) == 8'h01) inv = y[7:0];
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbt[x]  = b;
            isbt[b] = v;
        end
    endtask

    typedef logic [0:10][127:0] rk_t;

    function automatic rk_t expand(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rk_t         rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [7:0] bget(input logic [127:0] v, input int r, input int c);
        return v[127-8*(4*c+r) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbt[v[127-8*i -: 8]] : sbt[v[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = bget(v, r, inv ? (c - r + 4) % 4 : (c + r) % 4);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v, input bit inv);
        logic [7:0]   coef[4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], bget(v, k, c));
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        rk_t          rk;
        logic [127:0] s;
        rk = expand(key);
        s  = pt ^ rk[0];
        for (int r = 1; r <= 9; r++) s = mix_columns(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
        return shift_rows(sub_bytes(s, 0), 0) ^ rk[10];
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] key);
        rk_t          rk;
        logic [127:0] s;
        rk = expand(key);
        s  = ct ^ rk[10];
        for (int r = 9; r >= 1; r--) s = mix_columns(sub_bytes(shift_rows(s, 1), 1) ^ rk[r], 1);
        return sub_bytes(shift_rows(s, 1), 1) ^ rk[0];
    endfunction

    // ---------------- stimulus helpers
    task automatic send(input logic [127:0] ct, input logic [127:0] key, input bit hold);
        int k;
        bus.in_valid = 1'b1;
        bus.IN_DATA  = ct;
        bus.IN_KEY   = key;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check("accept_within_bound", (k < 100), 1);
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
    endtask

    // ---------------- monitor: pops the scoreboard on every output handshake
    initial begin : monitor
        logic [127:0] e;
        string        nm;
        forever begin
            @(negedge clk);
            if (resetn && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output got=%h exp=none", bus.OUT_DATA);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, bus.OUT_DATA, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           k, t_rise;
        logic [127:0] rkey, rct;
        build_tables();
        bus.in_valid  = 1'b0;
        bus.IN_DATA   = '0;
        bus.IN_KEY    = '0;
        bus.out_ready = 1'b1;
        resetn        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.OUT_DATA, 0);
        check("reset_in_ready", bus.in_ready, 1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1 with latency and key schedule checkpoints
        push(C1_PT, "c1_plaintext");
        send(C1_CT, C1_KEY, 0);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) check("c1_rk10", dut.key_reg, C1_RK10);
            if (k < 20) check("c1_no_early_valid", bus.out_valid, 0);
            if (bus.out_valid) break;
        end
        check("c1_latency", k, 20);
        check("c1_key_restored", dut.key_reg, C1_KEY);
        @(posedge clk);
        #1;

        // App. B under 15 cycles of backpressure
        bus.out_ready = 1'b0;
        push(B_PT, "appb_plaintext");
        send(B_CT, B_KEY, 0);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) check("appb_rk10", dut.key_reg, B_RK10);
            if (bus.out_valid) break;
        end
        check("appb_latency", k, 20);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_data", bus.OUT_DATA, B_PT);
            check("bp_in_ready_low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_data_kept", bus.OUT_DATA, B_PT);

        // Loopback through the behavioural encryptor
        push(LB_PT, "loopback_plaintext");
        send(model_enc(LB_PT, LB_KEY), LB_KEY, 0);
        wait_out(k);
        check("loopback_latency", k, 20);
        @(posedge clk);
        #1;

        // Reset at T12 abandons the block; the next C.1 block must still decrypt
        send(C1_CT, C1_KEY, 0);
        repeat (11) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_out_data", bus.OUT_DATA, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        push(C1_PT, "c1_after_reset");
        send(C1_CT, C1_KEY, 0);
        wait_out(k);
        check("after_reset_latency", k, 20);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        push(C1_PT, "b2b_first");
        push(B_PT, "b2b_second");
        send(C1_CT, C1_KEY, 1);
        bus.IN_DATA = B_CT;
        bus.IN_KEY  = B_KEY;
        wait_out(k);
        t_rise = cyc;
        check("b2b_first_latency", k, 20);
        send(B_CT, B_KEY, 0);
        check("b2b_accept_gap", cyc - t_rise, 2);
        wait_out(k);
        check("b2b_second_latency", k, 20);
        @(posedge clk);
        #1;

        // Randomized blocks with random output stalls
        for (int n = 0; n < 16; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rct  = {$urandom, $urandom, $urandom, $urandom};
            push(model_dec(rct, rkey), "rand_plaintext");
            bus.out_ready = 1'($urandom_range(0, 1));
            send(rct, rkey, 0);
            wait_out(k);
            check("rand_latency", k, 20);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher); the receive-side counterpart of the AES128 encryptor.
- Accepts one 128-bit ciphertext and the 128-bit cipher key over a valid/ready handshake.
- Expands the key forward to round key 10, then runs ten inverse rounds, one per cycle, deriving each earlier round key on the fly.
- Presents the plaintext on a valid/ready output.

Parameters:
- none (AES-128 only; Nk=4, Nr=10 are fixed)

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- in_valid  input  1  IN_DATA/IN_KEY valid
- in_ready  output  1  core can accept a block
- IN_DATA  input  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197
- IN_KEY  input  128  cipher key (round key 0), same byte order
- out_valid  output  1  OUT_DATA holds plaintext
- out_ready  input  1  downstream accepts OUT_DATA
- OUT_DATA  output  128  plaintext, same byte order

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. Ports are named clk and resetn.
- Reset action: on any edge with resetn=0:
  - state<=IDLE, round counter<=0, key/data registers<=0.
  - out_valid<=0, OUT_DATA<=0.
  - in_valid and out_ready are ignored.
  - Reset mid-operation abandons the block with no output.
- in_ready is combinational: in_ready = (state==IDLE). It reads 1 after the first reset edge.
- States: IDLE -> KEYEXP -> ROUND -> DONE -> IDLE.
- IDLE:
  - On an edge with in_valid&in_ready (edge T0): latch IN_DATA into ct_reg and IN_KEY into key_reg, set cnt<=1, go to KEYEXP.
  - Otherwise hold.
- KEYEXP (edges T1..T10):
  - key_reg <= forward expansion of key_reg with Rcon[cnt]: w0'=w0^SubWord(RotWord(w3))^Rcon, then w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - cnt increments each edge.
  - At T10 key_reg receives rk10. In the same edge data_reg <= ct_reg ^ rk10 (initial AddRoundKey), cnt<=10, go to ROUND.
- ROUND (edges T11..T20; cnt runs 10 down to 1):
  - prev_key = inverse expansion of key_reg with Rcon[cnt]: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon.
  - t = InvSubBytes(InvShiftRows(data_reg)) ^ prev_key.
  - data_reg <= (cnt>1) ? InvMixColumns(t) : t.
  - key_reg <= prev_key; cnt decrements.
  - At T20 (cnt==1): OUT_DATA<=t, out_valid<=1, go to DONE. key_reg then equals IN_KEY, which the bench checks.
- Latency: out_valid rises after edge T20, 20 cycles after the accepting edge. Throughput is one block per 22 cycles minimum.
- DONE:
  - OUT_DATA and out_valid are held stable while out_ready=0, for an unbounded time.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. OUT_DATA keeps its last value.
  - in_ready stays 0 in DONE, so a new block is accepted no earlier than the edge after the output handshake.
- Input behaviour:
  - in_valid outside IDLE is ignored; the source must hold it.
  - IN_DATA/IN_KEY may change freely after acceptance.
- Submodules:
  - Key schedule uses 4 forward S-box instances (the encryptor's sbox module).
  - The data path uses 16 inv_sbox instances (FIPS-197 Fig. 14 table, supplied as a separate file).
  - All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. InvMixColumns uses coefficients 0e,0b,0d,09 built from xtime chains.

Test Plan:
- FIPS-197 C.1: IN_KEY=000102030405060708090a0b0c0d0e0f, IN_DATA=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> OUT_DATA=00112233445566778899aabbccddeeff, out_valid high exactly 20 cycles after acceptance. Internal key_reg after T10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: IN_KEY=2b7e151628aed2a6abf7158809cf4f3c, IN_DATA=3925841d02dc09fbdc118597196a0b32 -> OUT_DATA=3243f6a8885a308d313198a2e0370734. rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: out_ready=0 for 15 cycles after out_valid -> OUT_DATA and out_valid stable, in_ready=0 throughout. Raising out_ready -> out_valid falls next edge and in_ready=1.
- Loopback with AES128 encryptor: IN_KEY=0123456789ABCDEF0123456789ABCDEF, plaintext d7e5dbd3324595f8fdc7d7c571da6c2a. Feed the encryptor's OUT_DATA to this core -> OUT_DATA=d7e5dbd3324595f8fdc7d7c571da6c2a.
- Reset mid-block: resetn=0 for one edge at T12 -> out_valid=0, OUT_DATA=0, in_ready=1 next cycle. A new C.1 block afterwards decrypts correctly.
- Back-to-back: in_valid held high with two vectors (C.1 then App. B) and out_ready=1 -> two correct outputs, the second accepted exactly 2 cycles after the first out_valid rises.
